result_streamer: RTL and testbench
==================================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter WORD_W, default 32, width of each result word in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter N_WORDS, default 2, number of result words per frame; SHALL be at least 1.
REQ-003 Parameter CKSUM_EN, default 1; 1 appends an XOR checksum byte, 0 omits it.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  design enable; low freezes all state.
REQ-007 start  input  1  single-cycle request to capture and stream a frame.
REQ-008 mode  input  3  regime code, placed in the header byte.
REQ-009 words  input  N_WORDS*WORD_W  flat word bus; word i occupies bits [i*WORD_W +: WORD_W].
REQ-010 host_ack  input  1  host accepts the current byte.
REQ-011 out_byte  output  8  current frame byte; 8'h00 when not valid.
REQ-012 out_valid  output  1  out_byte holds a frame byte.
REQ-013 busy  output  1  frame capture or streaming is in progress.
REQ-014 done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-015 Define NB = N_WORDS*WORD_W/8 data bytes; the frame is header, then NB data bytes, then the checksum if CKSUM_EN=1.
REQ-016 States: IDLE, HDR, DATA, CKS, FIN; the block SHALL contain no other state.
REQ-017 In IDLE, start=1 with ena=1 snapshots words and mode into internal registers, moves to HDR, and sets busy at the next edge.
REQ-018 Input changes after the snapshot SHALL NOT affect the frame in progress.
REQ-019 Header byte = {4'hA, 1'b0, mode}; it is valid starting the cycle after the start cycle (latency 1).
REQ-020 A byte transfers on a cycle where out_valid=1, host_ack=1 and ena=1; out_byte SHALL hold stable until that transfer.
REQ-021 DATA order: word 0 first, then word N_WORDS-1 last; within each word, most-significant byte first.
REQ-022 A byte counter of width $clog2(NB+1) tracks DATA progress; DATA exits after byte NB-1 transfers.
REQ-023 After DATA exits, the state moves to CKS if CKSUM_EN=1, otherwise to FIN.
REQ-024 Checksum = XOR of all NB data bytes (header excluded), accumulated as each data byte transfers.
REQ-025 FIN lasts one cycle: done=1, out_valid=0, busy=1, then IDLE with busy=0.
REQ-026 host_ack while out_valid=0 SHALL be ignored.
REQ-027 start while busy=1 SHALL be ignored; no queuing.
REQ-028 With ena=0, no state, counter or output changes, and start/host_ack are ignored.
REQ-029 start asserted in the same cycle done=1 is ignored; the next start is accepted from IDLE.

Reset
REQ-030 rst_n low, at any time including mid-frame, SHALL asynchronously force IDLE, counter=0, checksum=0, snapshots=0, out_byte=8'h00, out_valid=0, busy=0, done=0.
REQ-031 After rst_n deasserts, the first start is accepted no earlier than the first rising edge.

Structure
REQ-032 A shared package SHALL hold the state enum typedef, the header nibble constant 4'hA, and the mode width constant 3.
REQ-033 Single module; no sub-modules. The byte mux is an indexed slice of the snapshot register.

Verification
REQ-034 WORD_W=32, N_WORDS=2, CKSUM_EN=1, words {w1=32'hAABBCCDD, w0=32'h11223344}, mode=3'b101, host_ack=1 held -> bytes A5,11,22,33,44,AA,BB,CC,DD,44 on consecutive cycles, then done pulse.
REQ-035 Same frame with host_ack toggling 1 of every 3 cycles -> identical byte sequence, each byte held until acked, out_valid never drops mid-frame.
REQ-036 start pulsed during DATA, and words changed mid-frame -> second start ignored and original bytes streamed; a start after done is accepted and yields a fresh frame.
REQ-037 rst_n pulsed low during byte 5 -> all outputs 0 immediately; next start restarts at header A5.
REQ-038 ena=0 for 4 cycles mid-DATA with host_ack=1 -> out_byte frozen and no byte skipped; streaming resumes when ena returns high.
REQ-039 WORD_W=8, N_WORDS=1, CKSUM_EN=0, word 8'h5A, mode=3'b000 -> bytes A0,5A, then done.

Source files
------------

// File: rtl/result_streamer_pkg.sv
// Shared types and constants for the result byte streamer.
package result_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CKS,
        FIN
    } state_t;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;
    localparam int         MODE_W     = 3;

endpackage

// File: rtl/result_streamer.sv
// Captures a frame of result words and streams it byte by byte
// (header, data MSB-first per word, optional XOR checksum) to a host.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int N_WORDS  = 2,
    parameter int CKSUM_EN = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        start,
    input  logic [MODE_W-1:0]           mode,
    input  logic [N_WORDS*WORD_W-1:0]   words,
    input  logic                        host_ack,
    output logic [7:0]                  out_byte,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int BPW   = WORD_W / 8;
    localparam int NB    = N_WORDS * BPW;
    localparam int TOT_W = NB * 8;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int SEL_W = $clog2(TOT_W);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [7:0]          cksum;
    logic [7:0]          cksum_nxt;
    logic [TOT_W-1:0]    snap;
    logic [TOT_W-1:0]    stream;
    logic [MODE_W-1:0]   snap_mode;
    logic [SEL_W-1:0]    sel;
    logic                xfer;
    logic                last;

    // Reorder words into transmit order so data byte k sits at bits [k*8 +: 8].
    always_comb begin
        stream = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            for (int b = 0; b < BPW; b++) begin
                stream[(w*BPW + b)*8 +: 8] = words[w*WORD_W + (BPW-1-b)*8 +: 8];
            end
        end
    end

    assign xfer      = ena & out_valid & host_ack;
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign sel       = SEL_W'({cnt_nxt, 3'b000});
    assign last      = (cnt == CNT_W'(NB - 1));
    assign cksum_nxt = cksum ^ out_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cksum     <= '0;
            snap      <= '0;
            snap_mode <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (ena) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        snap      <= stream;
                        snap_mode <= mode;
                        cnt       <= '0;
                        cksum     <= '0;
                        out_byte  <= {HDR_NIBBLE, 1'b0, mode};
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        out_byte <= snap[7:0];
                        state    <= DATA;
                    end else begin
                        out_byte <= {HDR_NIBBLE, 1'b0, snap_mode};
                    end
                end
                DATA: begin
                    if (xfer) begin
                        cksum <= cksum_nxt;
                        cnt   <= cnt_nxt;
                        if (!last) begin
                            out_byte <= snap[sel +: 8];
                        end else if (CKSUM_EN != 0) begin
                            out_byte <= cksum_nxt;
                            state    <= CKS;
                        end else begin
                            out_byte  <= '0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end
                    end
                end
                CKS: begin
                    if (xfer) begin
                        out_byte  <= '0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: default 32x2 frame with checksum
// and an 8x1 frame without checksum.
module tb_result_streamer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [2:0]  mode;
    logic [63:0] words;
    logic        host_ack;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic        start8;
    logic [2:0]  mode8;
    logic [7:0]  word8;
    logic        ack8;
    logic [7:0]  ob8;
    logic        ov8;
    logic        busy8;
    logic        done8;

    int checks = 0;
    int errors = 0;

    bq_t frame1 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    bq_t frame2 = '{8'hA2, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hEB};

    always #5 clk = ~clk;

    result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .mode      (mode),
        .words     (words),
        .host_ack  (host_ack),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    result_streamer #(
        .WORD_W   (8),
        .N_WORDS  (1),
        .CKSUM_EN (0)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start8),
        .mode      (mode8),
        .words     (word8),
        .host_ack  (ack8),
        .out_byte  (ob8),
        .out_valid (ov8),
        .busy      (busy8),
        .done      (done8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input bq_t exp,
                             input int ack_per, input int start_at,
                             input int ena_at, input bit scramble);
        int  idx;
        int  cyc;
        bit  en;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            words = 64'hDEADBEEF_CAFEF00D;
            mode  = 3'b010;
        end
        check({tag, " hdr_valid"}, 32'(out_valid), 1);
        check({tag, " busy"}, 32'(busy), 1);
        idx = 0;
        cyc = 0;
        while (idx < exp.size() && cyc < 200) begin
            en       = !(ena_at >= 0 && cyc >= ena_at && cyc < ena_at + 4);
            ena      = en;
            host_ack = en ? (cyc % ack_per == 0) : 1'b1;
            start    = (cyc == start_at);
            check($sformatf("%s valid_c%0d", tag, cyc), 32'(out_valid), 1);
            check($sformatf("%s byte%0d_c%0d", tag, idx, cyc),
                  32'(out_byte), 32'(exp[idx]));
            if (en && host_ack) idx++;
            tick();
            cyc++;
        end
        start    = 1'b0;
        ena      = 1'b1;
        host_ack = 1'b0;
        check({tag, " complete"}, idx, exp.size());
        check({tag, " done"}, 32'(done), 1);
        check({tag, " fin_valid"}, 32'(out_valid), 0);
        check({tag, " fin_busy"}, 32'(busy), 1);
        check({tag, " fin_byte"}, 32'(out_byte), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " done_clr"}, 32'(done), 0);
        check({tag, " idle_busy"}, 32'(busy), 0);
        tick();
        check({tag, " fin_start_ignored"}, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        host_ack = 1'b0;
        mode     = 3'b101;
        words    = {32'hAABBCCDD, 32'h11223344};
        start8   = 1'b0;
        ack8     = 1'b0;
        mode8    = 3'b000;
        word8    = 8'h5A;
        repeat (2) tick();
        check("rst out_byte", 32'(out_byte), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        rst_n = 1'b1;
        host_ack = 1'b1;
        tick();
        check("idle ack ignored valid", 32'(out_valid), 0);
        check("idle ack ignored busy", 32'(busy), 0);
        host_ack = 1'b0;

        run_frame("ack1", frame1, 1, -1, -1, 1'b0);
        run_frame("ack3", frame1, 3, -1, -1, 1'b0);
        run_frame("midstart", frame1, 1, 3, -1, 1'b1);
        run_frame("fresh", frame2, 1, -1, -1, 1'b0);

        mode  = 3'b101;
        words = {32'hAABBCCDD, 32'h11223344};
        start = 1'b1;
        tick();
        start    = 1'b0;
        host_ack = 1'b1;
        repeat (4) tick();
        check("pre_rst byte", 32'(out_byte), 32'h44);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst byte", 32'(out_byte), 0);
        check("async_rst valid", 32'(out_valid), 0);
        check("async_rst busy", 32'(busy), 0);
        check("async_rst done", 32'(done), 0);
        #2 rst_n = 1'b1;
        host_ack = 1'b0;
        tick();
        check("post_rst idle", 32'(busy), 0);
        run_frame("post_rst", frame1, 1, -1, -1, 1'b0);

        run_frame("ena_off", frame1, 1, -1, 4, 1'b0);

        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("w8 hdr", 32'(ob8), 32'hA0);
        check("w8 hdr_valid", 32'(ov8), 1);
        check("w8 busy", 32'(busy8), 1);
        ack8 = 1'b1;
        tick();
        check("w8 data", 32'(ob8), 32'h5A);
        check("w8 data_valid", 32'(ov8), 1);
        tick();
        check("w8 done", 32'(done8), 1);
        check("w8 fin_valid", 32'(ov8), 0);
        check("w8 fin_busy", 32'(busy8), 1);
        ack8 = 1'b0;
        tick();
        check("w8 done_clr", 32'(done8), 0);
        check("w8 idle", 32'(busy8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
